ras_ctrl: RTL and testbench
===========================

# ras_ctrl

Sequencing controller in front of the return-address stack (RAS) in the frontend predictor. It turns call/return events from the branch-predict stage into single-operation push/pop strobes, and never asserts push and pop in the same cycle. It tracks occupancy, serialises coroutine (call+return) events over two cycles, and drains the stack on flush. It also returns a registered return-address prediction to the fetch stage.

## Interface
Parameters:
- DEPTH, 2, number of RAS entries; must equal the connected RAS depth; legal range ≥ 2.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  predict stage presents an event.
- req_ready_o  out  1  event accepted when valid && ready.
- req_call_i  in  1  event is a call (push link).
- req_ret_i  in  1  event is a return (pop).
- req_link_i  in  64  link address pushed on call.
- flush_i  in  1  mispredict/fence flush; drain the stack.
- ras_push_o  out  1  push strobe to RAS.
- ras_pop_o  out  1  pop strobe to RAS.
- ras_data_o  out  64  push data to RAS.
- ras_top_i  in  ariane_pkg::ras_t  RAS top entry (.ra, .valid).
- pred_valid_o  out  1  one-cycle pulse: valid return prediction.
- pred_ra_o  out  64  predicted return address.
- occupancy_o  out  CNT_W  valid entries tracked (0..DEPTH).
- overflow_o  out  1  pulse: push while full (bottom entry lost).
- underflow_o  out  1  pulse: return while empty.

## Operation
- States: IDLE, CORO, FLUSH. Occupancy counter cnt.
- req_ready_o = (state==IDLE) && !flush_i. This path is combinational.
- ras_push_o, ras_pop_o and ras_data_o are combinational from the state and the accepted event. Push and pop are never both 1.
- Call-only accept: push=1, data=req_link_i. cnt=min(cnt+1,DEPTH). overflow_o pulses next cycle if cnt==DEPTH at accept.
- Return-only accept, cnt>0: pop=1, cnt-1. The next cycle has pred_valid_o=ras_top_i.valid and pred_ra_o=ras_top_i.ra, both captured at accept.
- Return-only accept, cnt==0: no pop. Next cycle underflow_o=1, pred_valid_o=0, pred_ra_o=0.
- Call+return accept: pop as in return-only (or underflow if cnt==0). Capture req_link_i, then go to CORO. In CORO: push captured link, update cnt, return to IDLE.
- Neither call nor return with valid: event accepted, no action.
- Flush has the highest priority. No event is accepted in a flush cycle.
  - cnt==0: remain in IDLE.
  - cnt>0: enter FLUSH. The flush cycle itself issues no strobes.
  - In FLUSH: pop=1 each cycle, cnt-1. Return to IDLE on the cycle cnt reaches 0.
- flush_i while in FLUSH is ignored.
- flush_i while in CORO: the pending push is dropped. Go to FLUSH if cnt>0, else IDLE.
- pred_valid_o, overflow_o and underflow_o are registered single-cycle pulses.

## Timing
- Reset: state=IDLE, cnt=0, captured link=0, pred_valid_o=0, pred_ra_o=0, overflow_o=0, underflow_o=0.
- Strobe outputs are 0 at reset unless req_valid_i is presented while rst_ni is high.
- Call/return: strobe in the accept cycle. RAS and cnt update on that edge. Prediction and flags appear 1 cycle after accept.
- Coroutine: pop in cycle N, push in N+1, ready low in N+1. Next accept is no earlier than N+2.
- Flush drain: flush cycle, then cnt pop cycles. Ready is low during drain plus the flush cycle. Max DEPTH+1 cycles.
- Reset asserted mid-CORO/FLUSH: immediate return to IDLE with cnt=0. The RAS resets alongside.

## Configuration
- RAS_CTRL_COROUTINE_EN defined: call+return follows the two-cycle CORO sequence above.
- Not defined: CORO state is removed. Call+return is treated as return-only, and the link is discarded.

## Test plan
- Reset, then call link=0x1000, then return: push in cycle 1, pop in cycle 2. pred_valid_o=1 and pred_ra_o=0x1000 in cycle 3; occupancy 1→0.
- DEPTH=2, calls 0xA, 0xB, 0xC: overflow_o pulses after the third call; occupancy stays 2. Two returns predict 0xC then 0xB; a third return gives underflow_o=1 and pred_valid_o=0.
- Coroutine (macro on), occupancy 1 top 0x20, link 0x40: pop in cycle N, predict 0x20. Push 0x40 in N+1 with ready low. Occupancy stays 1; the next return predicts 0x40.
- Occupancy 2, flush_i=1 together with a valid call: call not accepted. Two pop cycles follow, then ready high; occupancy 0 and ras_top_i.valid=0.
- Flush during CORO: push suppressed, FLUSH drains the remaining entries, push never asserted.
- Check every cycle: ras_push_o && ras_pop_o is never 1. Macro off: call+return yields only a pop.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared frontend types used by the return-address-stack controller.
package ariane_pkg;

    // Return-address stack entry as presented by the RAS top-of-stack port.
    typedef struct packed {
        logic        valid;
        logic [63:0] ra;
    } ras_t;

endpackage

// File: rtl/ras_ctrl.sv
// ras_ctrl: sequences call/return events into exclusive push/pop strobes for
// the return-address stack, tracks occupancy, drains the stack on flush and
// returns a registered return-address prediction.
// Optional feature macro: RAS_CTRL_COROUTINE_EN (two-cycle call+return).
module ras_ctrl #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_call_i,
    input  logic               req_ret_i,
    input  logic [63:0]        req_link_i,
    input  logic               flush_i,
    output logic               ras_push_o,
    output logic               ras_pop_o,
    output logic [63:0]        ras_data_o,
    input  ariane_pkg::ras_t   ras_top_i,
    output logic               pred_valid_o,
    output logic [63:0]        pred_ra_o,
    output logic [CNT_W-1:0]   occupancy_o,
    output logic               overflow_o,
    output logic               underflow_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1
`ifdef RAS_CTRL_COROUTINE_EN
        ,
        CORO  = 2'd2
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pred_valid_q, pred_valid_d;
    logic [63:0]       pred_ra_q, pred_ra_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
`ifdef RAS_CTRL_COROUTINE_EN
    logic [63:0]       link_q, link_d;
`endif

    // Ready only in IDLE and never in a flush cycle.
    always_comb begin
        req_ready_o = (state_q == IDLE) && !flush_i;
    end

    // Next-state, occupancy, strobes and registered-flag inputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ras_push_o   = 1'b0;
        ras_pop_o    = 1'b0;
        ras_data_o   = '0;
        pred_valid_d = 1'b0;
        pred_ra_d    = pred_ra_q;
        ovf_d        = 1'b0;
        unf_d        = 1'b0;
`ifdef RAS_CTRL_COROUTINE_EN
        link_d       = link_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    if (cnt_q != '0) state_d = FLUSH;
                end else if (req_valid_i) begin
                    if (req_ret_i) begin
                        // Return (alone or first half of call+return).
                        if (cnt_q != '0) begin
                            ras_pop_o    = 1'b1;
                            cnt_d        = cnt_q - ONE_C;
                            pred_valid_d = ras_top_i.valid;
                            pred_ra_d    = ras_top_i.ra;
                        end else begin
                            unf_d     = 1'b1;
                            pred_ra_d = '0;
                        end
`ifdef RAS_CTRL_COROUTINE_EN
                        if (req_call_i) begin
                            link_d  = req_link_i;
                            state_d = CORO;
                        end
`endif
                    end else if (req_call_i) begin
                        ras_push_o = 1'b1;
                        ras_data_o = req_link_i;
                        if (cnt_q == DEPTH_C) ovf_d = 1'b1;
                        else                  cnt_d = cnt_q + ONE_C;
                    end
                end
            end
`ifdef RAS_CTRL_COROUTINE_EN
            CORO: begin
                // A flush here drops the pending push of the captured link.
                if (flush_i) begin
                    state_d = (cnt_q != '0) ? FLUSH : IDLE;
                end else begin
                    ras_push_o = 1'b1;
                    ras_data_o = link_q;
                    if (cnt_q == DEPTH_C) ovf_d = 1'b1;
                    else                  cnt_d = cnt_q + ONE_C;
                    state_d = IDLE;
                end
            end
`endif
            FLUSH: begin
                if (cnt_q != '0) begin
                    ras_pop_o = 1'b1;
                    cnt_d     = cnt_q - ONE_C;
                    if (cnt_q == ONE_C) state_d = IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, occupancy and registered prediction/flag outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_ra_q    <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
`ifdef RAS_CTRL_COROUTINE_EN
            link_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pred_valid_q <= pred_valid_d;
            pred_ra_q    <= pred_ra_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
`ifdef RAS_CTRL_COROUTINE_EN
            link_q       <= link_d;
`endif
        end
    end

    assign pred_valid_o = pred_valid_q;
    assign pred_ra_o    = pred_ra_q;
    assign occupancy_o  = cnt_q;
    assign overflow_o   = ovf_q;
    assign underflow_o  = unf_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed testbench for ras_ctrl with a small behavioural RAS attached.
module tb_ras_ctrl;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_call = 1'b0;
    logic             req_ret = 1'b0;
    logic [63:0]      req_link = '0;
    logic             flush = 1'b0;
    logic             ras_push;
    logic             ras_pop;
    logic [63:0]      ras_data;
    ariane_pkg::ras_t ras_top;
    ariane_pkg::ras_t ras_mem [DEPTH];
    logic             pred_valid;
    logic [63:0]      pred_ra;
    logic [CNT_W-1:0] occupancy;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    ras_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_call_i   (req_call),
        .req_ret_i    (req_ret),
        .req_link_i   (req_link),
        .flush_i      (flush),
        .ras_push_o   (ras_push),
        .ras_pop_o    (ras_pop),
        .ras_data_o   (ras_data),
        .ras_top_i    (ras_top),
        .pred_valid_o (pred_valid),
        .pred_ra_o    (pred_ra),
        .occupancy_o  (occupancy),
        .overflow_o   (overflow),
        .underflow_o  (underflow)
    );

    always #5 clk = ~clk;

    // Behavioural RAS: push shifts down (bottom lost when full), pop shifts up.
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) ras_mem[i] <= '0;
        end else if (ras_push) begin
            for (int i = DEPTH - 1; i > 0; i--) ras_mem[i] <= ras_mem[i-1];
            ras_mem[0] <= '{valid: 1'b1, ra: ras_data};
        end else if (ras_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) ras_mem[i] <= ras_mem[i+1];
            ras_mem[DEPTH-1] <= '0;
        end
    end
    assign ras_top = ras_mem[0];

    // Push and pop must never be asserted together.
    always begin
        @(negedge clk);
        #4;
        if (rst_ni) begin
            checks++;
            if (ras_push && ras_pop) begin
                errors++;
                $display("FAIL push_pop_exclusive: push=%0b pop=%0b, required not both 1", ras_push, ras_pop);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Apply one cycle of inputs just after the falling edge.
    task automatic step(input logic v, input logic c, input logic r, input logic [63:0] l, input logic f);
        @(negedge clk);
        req_valid = v; req_call = c; req_ret = r; req_link = l; flush = f;
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occ: got %0d exp 0", occupancy); end
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL rst_pred_valid: got %0b exp 0", pred_valid); end
        checks++; if (pred_ra !== 64'h0) begin errors++; $display("FAIL rst_pred_ra: got %0h exp 0", pred_ra); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rst_flags: got ovf=%0b unf=%0b exp 0/0", overflow, underflow); end
        checks++; if (ras_push !== 1'b0 || ras_pop !== 1'b0) begin errors++; $display("FAIL rst_strobes: got push=%0b pop=%0b exp 0/0", ras_push, ras_pop); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b exp 1", req_ready); end
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_call_return();
        step(1'b1, 1'b1, 1'b0, 64'h1000, 1'b0);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL cr_ready: got %0b exp 1", req_ready); end
        checks++; if (ras_push !== 1'b1 || ras_pop !== 1'b0) begin errors++; $display("FAIL cr_call_strobe: got push=%0b pop=%0b exp 1/0", ras_push, ras_pop); end
        checks++; if (ras_data !== 64'h1000) begin errors++; $display("FAIL cr_call_data: got %0h exp 1000", ras_data); end
        step(1'b1, 1'b0, 1'b1, 64'h0, 1'b0);
        checks++; if (ras_pop !== 1'b1 || ras_push !== 1'b0) begin errors++; $display("FAIL cr_ret_strobe: got push=%0b pop=%0b exp 0/1", ras_push, ras_pop); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL cr_occ1: got %0d exp 1", occupancy); end
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL cr_pred_valid: got %0b exp 1", pred_valid); end
        checks++; if (pred_ra !== 64'h1000) begin errors++; $display("FAIL cr_pred_ra: got %0h exp 1000", pred_ra); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL cr_occ0: got %0d exp 0", occupancy); end
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL cr_pred_pulse: got %0b exp 0", pred_valid); end
    endtask

    task automatic test_overflow_underflow();
        step(1'b1, 1'b1, 1'b0, 64'hA, 1'b0);
        step(1'b1, 1'b1, 1'b0, 64'hB, 1'b0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ou_no_ovf: got %0b exp 0", overflow); end
        step(1'b1, 1'b1, 1'b0, 64'hC, 1'b0);
        checks++; if (occupancy !== 2'd2 || ras_push !== 1'b1) begin errors++; $display("FAIL ou_full_push: got occ=%0d push=%0b exp 2/1", occupancy, ras_push); end
        step(1'b1, 1'b0, 1'b1, 64'h0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ou_ovf: got %0b exp 1", overflow); end
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL ou_occ_sat: got %0d exp 2", occupancy); end
        step(1'b1, 1'b0, 1'b1, 64'h0, 1'b0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ou_ovf_pulse: got %0b exp 0", overflow); end
        checks++; if (pred_valid !== 1'b1 || pred_ra !== 64'hC) begin errors++; $display("FAIL ou_pred_c: got v=%0b ra=%0h exp 1/c", pred_valid, pred_ra); end
        step(1'b1, 1'b0, 1'b1, 64'h0, 1'b0);
        checks++; if (pred_valid !== 1'b1 || pred_ra !== 64'hB) begin errors++; $display("FAIL ou_pred_b: got v=%0b ra=%0h exp 1/b", pred_valid, pred_ra); end
        checks++; if (ras_pop !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL ou_empty_ret: got pop=%0b occ=%0d exp 0/0", ras_pop, occupancy); end
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL ou_unf: got %0b exp 1", underflow); end
        checks++; if (pred_valid !== 1'b0 || pred_ra !== 64'h0) begin errors++; $display("FAIL ou_unf_pred: got v=%0b ra=%0h exp 0/0", pred_valid, pred_ra); end
    endtask

    task automatic test_flush();
        step(1'b1, 1'b1, 1'b0, 64'h11, 1'b0);
        step(1'b1, 1'b1, 1'b0, 64'h22, 1'b0);
        step(1'b1, 1'b1, 1'b0, 64'h33, 1'b1);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fl_ready_flush: got %0b exp 0", req_ready); end
        checks++; if (ras_push !== 1'b0 || ras_pop !== 1'b0) begin errors++; $display("FAIL fl_no_strobe: got push=%0b pop=%0b exp 0/0", ras_push, ras_pop); end
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        checks++; if (ras_pop !== 1'b1 || req_ready !== 1'b0 || occupancy !== 2'd2) begin errors++; $display("FAIL fl_drain1: got pop=%0b rdy=%0b occ=%0d exp 1/0/2", ras_pop, req_ready, occupancy); end
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checks++; if (ras_pop !== 1'b1 || req_ready !== 1'b0 || occupancy !== 2'd1) begin errors++; $display("FAIL fl_drain2: got pop=%0b rdy=%0b occ=%0d exp 1/0/1", ras_pop, req_ready, occupancy); end
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checks++; if (req_ready !== 1'b1 || ras_pop !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL fl_done: got rdy=%0b pop=%0b occ=%0d exp 1/0/0", req_ready, ras_pop, occupancy); end
        checks++; if (ras_top.valid !== 1'b0) begin errors++; $display("FAIL fl_top_valid: got %0b exp 0", ras_top.valid); end
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fl_empty_ready: got %0b exp 0", req_ready); end
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checks++; if (req_ready !== 1'b1 || ras_pop !== 1'b0) begin errors++; $display("FAIL fl_empty_idle: got rdy=%0b pop=%0b exp 1/0", req_ready, ras_pop); end
    endtask

`ifdef RAS_CTRL_COROUTINE_EN
    task automatic test_coroutine();
        step(1'b1, 1'b1, 1'b0, 64'h20, 1'b0);
        step(1'b1, 1'b1, 1'b1, 64'h40, 1'b0);
        checks++; if (ras_pop !== 1'b1 || ras_push !== 1'b0) begin errors++; $display("FAIL co_pop: got push=%0b pop=%0b exp 0/1", ras_push, ras_pop); end
        step(1'b1, 1'b0, 1'b1, 64'h0, 1'b0);
        checks++; if (ras_push !== 1'b1 || ras_data !== 64'h40 || req_ready !== 1'b0) begin errors++; $display("FAIL co_push: got push=%0b data=%0h rdy=%0b exp 1/40/0", ras_push, ras_data, req_ready); end
        checks++; if (pred_valid !== 1'b1 || pred_ra !== 64'h20) begin errors++; $display("FAIL co_pred: got v=%0b ra=%0h exp 1/20", pred_valid, pred_ra); end
        step(1'b1, 1'b0, 1'b1, 64'h0, 1'b0);
        checks++; if (occupancy !== 2'd1 || ras_pop !== 1'b1) begin errors++; $display("FAIL co_occ: got occ=%0d pop=%0b exp 1/1", occupancy, ras_pop); end
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checks++; if (pred_ra !== 64'h40 || pred_valid !== 1'b1) begin errors++; $display("FAIL co_pred2: got v=%0b ra=%0h exp 1/40", pred_valid, pred_ra); end
        step(1'b1, 1'b1, 1'b0, 64'h50, 1'b0);
        step(1'b1, 1'b1, 1'b0, 64'h60, 1'b0);
        step(1'b1, 1'b1, 1'b1, 64'h70, 1'b0);
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        checks++; if (ras_push !== 1'b0 || ras_pop !== 1'b0 || occupancy !== 2'd1) begin errors++; $display("FAIL cf_drop: got push=%0b pop=%0b occ=%0d exp 0/0/1", ras_push, ras_pop, occupancy); end
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checks++; if (ras_pop !== 1'b1 || ras_push !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL cf_drain: got push=%0b pop=%0b rdy=%0b exp 0/1/0", ras_push, ras_pop, req_ready); end
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checks++; if (req_ready !== 1'b1 || occupancy !== 2'd0 || ras_push !== 1'b0) begin errors++; $display("FAIL cf_done: got rdy=%0b occ=%0d push=%0b exp 1/0/0", req_ready, occupancy, ras_push); end
    endtask
`else
    task automatic test_coroutine();
        step(1'b1, 1'b1, 1'b0, 64'h20, 1'b0);
        step(1'b1, 1'b1, 1'b1, 64'h40, 1'b0);
        checks++; if (ras_pop !== 1'b1 || ras_push !== 1'b0) begin errors++; $display("FAIL nc_pop_only: got push=%0b pop=%0b exp 0/1", ras_push, ras_pop); end
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checks++; if (ras_push !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL nc_no_push: got push=%0b rdy=%0b exp 0/1", ras_push, req_ready); end
        checks++; if (pred_valid !== 1'b1 || pred_ra !== 64'h20 || occupancy !== 2'd0) begin errors++; $display("FAIL nc_pred: got v=%0b ra=%0h occ=%0d exp 1/20/0", pred_valid, pred_ra, occupancy); end
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checks++; if (occupancy !== 2'd0 || ras_top.valid !== 1'b0) begin errors++; $display("FAIL nc_link_dropped: got occ=%0d top_v=%0b exp 0/0", occupancy, ras_top.valid); end
    endtask
`endif

    task automatic test_reset_mid_flush();
        step(1'b1, 1'b1, 1'b0, 64'h1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 64'h2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checks++; if (ras_pop !== 1'b1) begin errors++; $display("FAIL rm_in_flush: got pop=%0b exp 1", ras_pop); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (occupancy !== 2'd0 || req_ready !== 1'b1 || ras_pop !== 1'b0) begin errors++; $display("FAIL rm_reset: got occ=%0d rdy=%0b pop=%0b exp 0/1/0", occupancy, req_ready, ras_pop); end
        @(negedge clk);
        rst_ni = 1'b1;
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        checks++; if (occupancy !== 2'd0 || ras_pop !== 1'b0) begin errors++; $display("FAIL rm_after: got occ=%0d pop=%0b exp 0/0", occupancy, ras_pop); end
    endtask

    initial begin
        test_reset();
        test_call_return();
        test_overflow_underflow();
        test_flush();
        test_coroutine();
        test_reset_mid_flush();
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
